// File: rtl/eight_queen_pkg.sv
// Shared types and constants for the stacked N-queens solver.
package eight_queen_pkg;

  localparam int unsigned MAX_N = 8;
  localparam int unsigned COL_W = 3;
  localparam int unsigned SP_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    ADVANCE,
    FINISH
  } state_t;

  typedef logic [MAX_N-1:0][COL_W-1:0] stack_t;

  function automatic logic [COL_W-1:0] abs_diff(input logic [COL_W-1:0] a,
                                                input logic [COL_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [MAX_N-1:0] col_onehot(input logic [COL_W-1:0] c);
    return MAX_N'(1) << c;
  endfunction

endpackage

// File: rtl/queen_conflict_check.sv
// Tests a candidate column against every queen already placed below the stack pointer.
module queen_conflict_check
  import eight_queen_pkg::*;
(
  input  stack_t           i_stack,
  input  logic [SP_W-1:0]  i_sp,
  input  logic [COL_W-1:0] i_col,
  output logic             o_conflict
);

  always_comb begin
    o_conflict = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (SP_W'(i) < i_sp) begin
        if (i_stack[i] == i_col) begin
          o_conflict = 1'b1;
        end
        // Diagonal hit when column distance equals row distance.
        if ({1'b0, abs_diff(i_stack[i], i_col)} == (i_sp - SP_W'(i))) begin
          o_conflict = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stacked_eight_queen.sv
// Backtracking N-queens accelerator; presents the found board one row per cycle.
// Optional build macro ALL_SOLUTIONS_EN: a start after a solution resumes to the next one.
module stacked_eight_queen
  import eight_queen_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic       clk,
  input  logic       user_reset,
  input  logic       start,
  output logic       ready,
  output logic       done,
  output logic       no_answer,
  output logic [7:0] out_bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);
  localparam logic [SP_W-1:0]  LAST_SP  = SP_W'(N - 1);

  state_t           r_state, w_state_nxt;
  stack_t           r_stack;
  logic [SP_W-1:0]  r_sp, w_sp_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [COL_W-1:0] r_row, w_row_nxt;
  logic             r_no_answer, w_na_nxt;
  logic             r_start_q;
  logic             w_push;
  logic             w_conflict;
  logic             w_ready;
  logic             w_start_acc;
  logic [COL_W-1:0] w_pop_idx;
  logic [SP_W-1:0]  w_sp_m1;

  queen_conflict_check u_check (
    .i_stack    (r_stack),
    .i_sp       (r_sp),
    .i_col      (r_col),
    .o_conflict (w_conflict)
  );

  assign w_ready     = (r_state == IDLE) || (r_state == FINISH);
  assign w_start_acc = start && !r_start_q && w_ready;
  assign w_sp_m1     = r_sp - SP_W'(1);
  assign w_pop_idx   = COL_W'(w_sp_m1);

  always_ff @(posedge clk or negedge user_reset) begin
    if (!user_reset) begin
      r_state     <= IDLE;
      r_sp        <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_no_answer <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sp        <= w_sp_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_no_answer <= w_na_nxt;
      r_start_q   <= start;
    end
  end

  always_ff @(posedge clk or negedge user_reset) begin
    if (!user_reset) begin
      r_stack <= '0;
    end else if (w_push) begin
      r_stack[COL_W'(r_sp)] <= r_col;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sp_nxt    = r_sp;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_na_nxt    = r_no_answer;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = SEARCH;
          w_sp_nxt    = '0;
          w_col_nxt   = '0;
          w_na_nxt    = 1'b0;
        end
      end
      SEARCH: begin
        if (!w_conflict) begin
          w_push    = 1'b1;
          w_sp_nxt  = r_sp + SP_W'(1);
          w_col_nxt = '0;
          if (r_sp == LAST_SP) begin
            w_state_nxt = FINISH;
            w_na_nxt    = 1'b0;
            w_row_nxt   = '0;
          end
        end else if (r_col != LAST_COL) begin
          w_col_nxt = r_col + COL_W'(1);
        end else if (r_sp == '0) begin
          w_state_nxt = FINISH;
          w_na_nxt    = 1'b1;
          w_row_nxt   = '0;
        end else begin
          w_sp_nxt    = w_sp_m1;
          w_col_nxt   = r_stack[w_pop_idx];
          w_state_nxt = ADVANCE;
        end
      end
      ADVANCE: begin
        if (r_col != LAST_COL) begin
          w_col_nxt   = r_col + COL_W'(1);
          w_state_nxt = SEARCH;
        end else if (r_sp == '0) begin
          w_state_nxt = FINISH;
          w_na_nxt    = 1'b1;
          w_row_nxt   = '0;
        end else begin
          w_sp_nxt  = w_sp_m1;
          w_col_nxt = r_stack[w_pop_idx];
        end
      end
      FINISH: begin
        w_row_nxt = (r_row == LAST_COL) ? '0 : r_row + COL_W'(1);
        if (w_start_acc) begin
          w_state_nxt = SEARCH;
          w_sp_nxt    = '0;
          w_col_nxt   = '0;
          w_na_nxt    = 1'b0;
`ifdef ALL_SOLUTIONS_EN
          // Resume: treat the top queen as conflicting so ADVANCE moves past this board.
          if (!r_no_answer) begin
            w_state_nxt = ADVANCE;
            w_sp_nxt    = w_sp_m1;
            w_col_nxt   = r_stack[w_pop_idx];
          end
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ready     = w_ready;
  assign done      = (r_state == FINISH);
  assign no_answer = (r_state == FINISH) && r_no_answer;
  assign out_bus   = ((r_state == FINISH) && !r_no_answer) ? col_onehot(r_stack[r_row]) : '0;

endmodule

// File: tb/tb_stacked_eight_queen.sv
// Directed bench: N=8/4/3/1 solver instances sharing clock and reset.
module tb_stacked_eight_queen;

  typedef logic [7:0] board_t [8];

  logic       clk;
  logic       r_rst_n;
  logic       r_start [4];
  logic       w_ready [4];
  logic       w_done  [4];
  logic       w_na    [4];
  logic [7:0] w_bus   [4];

  int n_assert;
  int n_fail;

  board_t exp8;
  board_t exp4;

  stacked_eight_queen #(.N(8)) u_q8 (.clk(clk), .user_reset(r_rst_n), .start(r_start[0]),
    .ready(w_ready[0]), .done(w_done[0]), .no_answer(w_na[0]), .out_bus(w_bus[0]));
  stacked_eight_queen #(.N(4)) u_q4 (.clk(clk), .user_reset(r_rst_n), .start(r_start[1]),
    .ready(w_ready[1]), .done(w_done[1]), .no_answer(w_na[1]), .out_bus(w_bus[1]));
  stacked_eight_queen #(.N(3)) u_q3 (.clk(clk), .user_reset(r_rst_n), .start(r_start[2]),
    .ready(w_ready[2]), .done(w_done[2]), .no_answer(w_na[2]), .out_bus(w_bus[2]));
  stacked_eight_queen #(.N(1)) u_q1 (.clk(clk), .user_reset(r_rst_n), .start(r_start[3]),
    .ready(w_ready[3]), .done(w_done[3]), .no_answer(w_na[3]), .out_bus(w_bus[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_edge(input int k);
    @(negedge clk) r_start[k] = 1'b0;
    @(negedge clk) r_start[k] = 1'b1;
  endtask

  task automatic wait_done(input int k, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (w_done[k]) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_in_budget"}, 32'(seen), 32'd1);
  endtask

  // Samples n rows starting at the current negedge; returns on the negedge after the last.
  task automatic read_board(input int k, input int n, output board_t b);
    for (int i = 0; i < 8; i++) b[i] = 8'h00;
    for (int i = 0; i < n; i++) begin
      b[i] = w_bus[k];
      @(negedge clk);
    end
  endtask

  task automatic check_board(input int k, input int n, input board_t exp, input string tag);
    board_t got;
    for (int rot = 0; rot < 2; rot++) begin
      read_board(k, n, got);
      for (int i = 0; i < n; i++)
        chk($sformatf("%s_row%0d_rot%0d", tag, i, rot), 32'(got[i]), 32'(exp[i]));
    end
  endtask

`ifdef ALL_SOLUTIONS_EN
  function automatic int col_of(input logic [7:0] m);
    int c;
    c = -1;
    for (int i = 0; i < 8; i++)
      if (m == (8'h01 << i)) c = i;
    return c;
  endfunction

  function automatic bit board_ok(input board_t b);
    int ci, cj, d;
    for (int i = 0; i < 8; i++) begin
      ci = col_of(b[i]);
      if (ci < 0) return 1'b0;
      for (int j = 0; j < i; j++) begin
        cj = col_of(b[j]);
        d  = (ci > cj) ? ci - cj : cj - ci;
        if (ci == cj || d == i - j) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [23:0] board_code(input board_t b);
    logic [23:0] code;
    code = '0;
    for (int i = 0; i < 8; i++) code = {code[20:0], 3'(col_of(b[i]))};
    return code;
  endfunction
`endif

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp8 = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
    exp4 = '{8'h02, 8'h08, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) r_start[k] = 1'b0;
    r_rst_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(w_ready[k]), 32'd1);
      chk($sformatf("rst_done%0d", k), 32'(w_done[k]), 32'd0);
      chk($sformatf("rst_na%0d", k), 32'(w_na[k]), 32'd0);
      chk($sformatf("rst_bus%0d", k), 32'(w_bus[k]), 32'd0);
    end
    r_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_search_done", 32'(w_done[0]), 32'd0);
    chk("idle_no_search_ready", 32'(w_ready[0]), 32'd1);

    // N=8 first solution
    start_edge(0);
    @(negedge clk);
    chk("q8_busy_ready", 32'(w_ready[0]), 32'd0);
    wait_done(0, "q8");
    chk("q8_na", 32'(w_na[0]), 32'd0);
    check_board(0, 8, exp8, "q8");

    // Held-high start must not retrigger
    repeat (30) @(negedge clk);
    chk("held_start_done", 32'(w_done[0]), 32'd1);
    chk("held_start_ready", 32'(w_ready[0]), 32'd1);

    // N=4, N=3, N=1
    start_edge(1);
    wait_done(1, "q4");
    chk("q4_na", 32'(w_na[1]), 32'd0);
    check_board(1, 4, exp4, "q4");

    start_edge(2);
    wait_done(2, "q3");
    chk("q3_na", 32'(w_na[2]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q3_bus%0d", i), 32'(w_bus[2]), 32'd0);
      @(negedge clk);
    end

    start_edge(3);
    wait_done(3, "q1");
    chk("q1_na", 32'(w_na[3]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q1_bus%0d", i), 32'(w_bus[3]), 32'd1);
      @(negedge clk);
    end

`ifdef ALL_SOLUTIONS_EN
    begin
      board_t      got;
      logic [23:0] prev;
      int          nsol;
      bit          ended;
      prev  = 24'o04752613;
      nsol  = 1;
      ended = 1'b0;
      for (int s = 0; s < 100; s++) begin
        start_edge(0);
        @(negedge clk);
        chk("resume_done_low", 32'(w_done[0]), 32'd0);
        wait_done(0, "resume");
        if (w_na[0]) begin
          ended = 1'b1;
          chk("last_bus_zero", 32'(w_bus[0]), 32'd0);
          break;
        end
        read_board(0, 8, got);
        chk($sformatf("sol%0d_valid", nsol), 32'(board_ok(got)), 32'd1);
        chk($sformatf("sol%0d_ascending", nsol), 32'(board_code(got) > prev), 32'd1);
        prev = board_code(got);
        nsol++;
      end
      chk("all_ended", 32'(ended), 32'd1);
      chk("all_count", 32'(nsol), 32'd92);
      start_edge(0);
      wait_done(0, "after_last");
      chk("after_last_na", 32'(w_na[0]), 32'd0);
      check_board(0, 8, exp8, "after_last");
    end
`else
    start_edge(0);
    @(negedge clk);
    chk("restart_done_low", 32'(w_done[0]), 32'd0);
    wait_done(0, "restart");
    chk("restart_na", 32'(w_na[0]), 32'd0);
    check_board(0, 8, exp8, "restart");
`endif

    // Reset in the middle of a search
    start_edge(0);
    repeat (100) @(negedge clk);
    chk("mid_busy_done", 32'(w_done[0]), 32'd0);
    #2 r_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(w_ready[0]), 32'd1);
    chk("mid_rst_done", 32'(w_done[0]), 32'd0);
    chk("mid_rst_na", 32'(w_na[0]), 32'd0);
    chk("mid_rst_bus", 32'(w_bus[0]), 32'd0);
    r_start[0] = 1'b0;
    repeat (5) @(negedge clk);
    r_rst_n = 1'b1;
    start_edge(0);
    wait_done(0, "post_rst");
    chk("post_rst_na", 32'(w_na[0]), 32'd0);
    check_board(0, 8, exp8, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stacked_eight_queen.md
Name: stacked_eight_queen

Overview:
- Hardware N-queens solver using an explicit backtracking stack (one column entry per placed row).
- On start, searches column placements row by row in lexicographic order and reports the first valid board.
- Streams the board one row per cycle as a one-hot column mask on out_bus.
- Standalone accelerator; handshake through ready/start/done/no_answer.

Parameters:
- N, 8, board size and stack depth; legal range 1..8. out_bus stays 8 bits wide; bits above N-1 are always 0.

Ports:
- clk  input  1  rising-edge clock.
- user_reset  input  1  asynchronous, active-low reset.
- start  input  1  request a search; edge-detected internally.
- ready  output  1  high when a new start is accepted.
- done  output  1  search finished; held until next accepted start or reset.
- no_answer  output  1  valid while done=1; 1 means no solution exists.
- out_bus  output  8  one-hot column mask of the currently presented row; bit c = column c.

Behaviour:
- Reset values while user_reset=0: ready=1, done=0, no_answer=0, out_bus=0, stack pointer sp=0, internal start_q=0. Reset is honoured immediately, including mid-search.
- Start acceptance: start=1 and start_q=0 while ready=1. start_q registers start every cycle. A held-high start never triggers a second search.
- States:
  - IDLE: ready=1, done=0, out_bus=0.
  - SEARCH: ready=0. Candidate column col for row sp. col is compared against stack[0..sp-1]. A conflict is the same column, or |Δcol| equal to |Δrow|. One candidate is tested per cycle.
  - ADVANCE: ready=0. Handles the column after a backtrack.
  - FINISH: ready=1, done=1.
- SEARCH transitions:
  - Safe candidate: stack[sp]<=col, sp++, col<=0. If sp was N-1, go to FINISH with no_answer=0.
  - Unsafe candidate and col<N-1: col++.
  - Unsafe candidate and col=N-1, sp=0: go to FINISH with no_answer=1.
  - Unsafe candidate and col=N-1, sp>0: pop (sp--, col<=stack[sp-1]) and go to ADVANCE.
- ADVANCE transitions:
  - col<N-1: col++, return to SEARCH.
  - col=N-1, sp=0: FINISH with no_answer=1.
  - col=N-1, sp>0: pop again.
- FINISH output with a solution:
  - A row counter starts at 0 on the first FINISH cycle and wraps after N-1.
  - out_bus = one-hot(stack[row]), so rows 0..N-1 are presented continuously in rotation.
- FINISH output with no_answer=1: out_bus=0.
- Accepted start from FINISH: clears done and no_answer, sets sp=0 and col=0, and restarts the search from an empty board.
- Latency: bounded by backtracking. For N=8 it is under 20000 cycles.

Optional Feature:
- Macro: ALL_SOLUTIONS_EN.
- Defined: an accepted start from FINISH (after a solution) resumes the search. The top stack entry is treated as a conflict: pop into ADVANCE, which yields the next solution in lexicographic order. After the last solution, FINISH with no_answer=1. A start from that state, or from IDLE, restarts from an empty board.
- Not defined: every accepted start restarts from an empty board.

Decomposition:
- Package eight_queen_pkg holds:
  - MAX_N=8.
  - COL_W=3.
  - State enum {IDLE, SEARCH, ADVANCE, FINISH}.
- One combinational sub-module, queen_conflict_check. Inputs: stack contents, sp, col. Output: conflict. It compares against entries below sp only.

Test Plan:
- Reset: hold user_reset=0 for 5 cycles, then release -> ready=1, done=0, no_answer=0, out_bus=0x00; no search starts without a start edge.
- N=8 start: start rises -> done within 20000 cycles, no_answer=0. out_bus on consecutive cycles from done rise = 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08, then repeats.
- N=4: start -> done=1, no_answer=0, out_bus sequence 0x02,0x08,0x01,0x04.
- N=3: start -> done=1, no_answer=1, out_bus=0x00; N=1 -> done=1, out_bus=0x01.
- Reset mid-search: pull user_reset low 100 cycles after start -> outputs go to reset values at once. After release and a new start edge, the N=8 result matches the N=8 start scenario exactly.
- Held start and restart: keep start high after done -> done stays 1, no restart. Drop start then raise it -> done falls, search reruns, same board. With ALL_SOLUTIONS_EN and N=8, repeated start edges yield 92 distinct solutions, then no_answer=1.
